// File: rtl/mini_alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the Mini ALU sequencer.
package mini_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NEG = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/mini_alu_seq_if.sv
// Operand and result channels of the Mini ALU sequencer.
// Both channels use valid/ready: a transfer happens on the rising edge where valid && ready; valid holds its payload until then.
interface mini_alu_seq_if #(parameter int WIDTH = 6) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

endinterface

// File: rtl/alu_mul_shift6.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles per product.
module alu_mul_shift6 #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier_sh;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic               done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            acc       <= '0;
            mcand_sh  <= {{WIDTH{1'b0}}, mcand};
            mplier_sh <= mplier;
            cnt       <= '0;
            busy      <= 1'b1;
            done_q    <= 1'b0;
        end else if (busy) begin
            // The multiplicand shifts left in step with the counter, so each add lands at weight 2^cnt.
            if (mplier_sh[0]) begin
                acc <= acc + mcand_sh;
            end
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            if (cnt == CW'(WIDTH - 1)) begin
                busy   <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign product = acc;
    assign done    = done_q;

endmodule

// File: rtl/mini_alu_seq.sv
// Mini ALU sequencer: accepts an opcode and operands, runs single-cycle ops or the shift-add multiplier, returns a held result.
module mini_alu_seq
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mini_alu_seq_if.slave  bus,
    output state_t         dbg_state
);

    localparam int M = WIDTH - 1;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;
    logic               exec_ok;
    logic               accept;
    logic               mul_start;
    logic [2*WIDTH-1:0] product;
    logic               mul_done;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   zn_src;
    flags_t             alu_flags;

    assign accept    = bus.in_valid && (state == IDLE);
    assign mul_start = accept && (bus.op == OP_MUL);

    alu_mul_shift6 #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .mcand   (bus.a),
        .mplier  (bus.b),
        .product (product),
        .done    (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = (bus.op == OP_MUL) ? MUL : EXEC;
            EXEC: if (exec_ok)      state_nxt = DONE;
            MUL:  if (mul_done)     state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // SUB/CMP add the inverted subtrahend plus one; the carry out is the no-borrow bit.
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (op_q)
            OP_ADD: begin
                alu_res     = add_full[M:0];
                alu_flags.c = add_full[WIDTH];
                alu_flags.v = (a_q[M] == b_q[M]) && (add_full[M] != a_q[M]);
            end
            OP_SUB, OP_CMP: begin
                alu_res     = (op_q == OP_CMP) ? a_q : sub_full[M:0];
                alu_flags.c = sub_full[WIDTH];
                alu_flags.v = (a_q[M] != b_q[M]) && (sub_full[M] != a_q[M]);
            end
            OP_NEG: begin
                alu_res     = ~a_q + WIDTH'(1);
                alu_flags.c = (a_q == '0);
                alu_flags.v = (a_q == {1'b1, {M{1'b0}}});
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
        // CMP returns a untouched but reports zero/negative of the difference.
        zn_src      = (op_q == OP_CMP) ? sub_full[M:0] : alu_res;
        alu_flags.z = (zn_src == '0);
        alu_flags.n = zn_src[M];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            exec_ok  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            // Result is captured on the first EXEC cycle; the second cycle hands over to DONE.
            exec_ok <= (state == EXEC) && !exec_ok;
            if ((state == EXEC) && !exec_ok) begin
                result_q <= alu_res;
                flags_q  <= alu_flags;
            end else if ((state == MUL) && mul_done) begin
                result_q  <= product[M:0];
                flags_q.z <= (product[M:0] == '0);
                flags_q.n <= product[M];
                flags_q.c <= |product[2*WIDTH-1:WIDTH];
                flags_q.v <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;
    assign dbg_state     = state;

endmodule
